// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the fetch stage of the 9-bit accumulator core.
package fetch_unit_pkg;

    localparam int PC_W   = 10;
    localparam int LUT_AW = 5;
    localparam int OFF_W  = 5;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2,
        DONE   = 2'd3
    } fetch_state_t;

    localparam logic [PC_W-1:0] JUMP_TABLE [2**LUT_AW] = '{
        0: 10'd0,
        1: 10'd16,
        2: 10'd64,
        3: 10'd512,
        default: 10'd0
    };

endpackage

// File: rtl/fetch_unit_jump_lut.sv
// Combinational jump-table lookup: jump index to absolute PC target.
module jump_lut
    import fetch_unit_pkg::*;
(
    input  logic [LUT_AW-1:0] jump_idx,
    output logic [PC_W-1:0]   target
);

    assign target = JUMP_TABLE[jump_idx];

endmodule

// File: rtl/fetch_unit.sv
// PC / instruction-fetch stage: start, stall, halt, jump, branch and end-of-program sequencing.
// Optional FETCH_PERF_CNT_EN adds a saturating fetched-instruction counter (instr_cnt).
//
//   state  | meaning
//   IDLE   | out of reset, waiting for start
//   RUN    | fetching; prog_ctr word is valid
//   HALTED | halted by halt, PC frozen until start
//   DONE   | END_ADDR fetched without redirect, sticky
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [PC_W-1:0] START_ADDR = 10'd0,
    parameter logic [PC_W-1:0] END_ADDR   = 10'd1023
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              start,
    input  logic              halt,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [LUT_AW-1:0] jump_idx,
    input  logic              branch_en,
    input  logic              branch_cond,
    input  logic [OFF_W-1:0]  br_offset,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       instr_cnt,
`endif
    output logic [PC_W-1:0]   prog_ctr,
    output logic              running,
    output logic              done
);

    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] jump_target;
    logic [PC_W-1:0] offset_ext;

    jump_lut u_lut (
        .jump_idx (jump_idx),
        .target   (jump_target)
    );

    assign offset_ext = {{(PC_W-OFF_W){br_offset[OFF_W-1]}}, br_offset};

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q <= IDLE;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        if (start) begin
            state_d = RUN;
            pc_d    = START_ADDR;
        end else if (state_q == RUN) begin
            if (halt) begin
                state_d = HALTED;
            end else if (stall) begin
                pc_d = pc_q;
            end else if (jump_en) begin
                pc_d = jump_target;
            end else if (branch_en) begin
                // a non-taken branch still advances, even at END_ADDR
                pc_d = branch_cond ? pc_q + offset_ext : pc_q + PC_W'(1);
            end else if (pc_q == END_ADDR) begin
                state_d = DONE;
            end else begin
                pc_d = pc_q + PC_W'(1);
            end
        end
    end

    assign prog_ctr = pc_q;
    assign running  = (state_q == RUN);
    assign done     = (state_q == DONE);

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] cnt_q;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_q <= '0;
        end else if (start) begin
            cnt_q <= '0;
        end else if (state_q == RUN && !halt && !stall && cnt_q != 16'hFFFF) begin
            cnt_q <= cnt_q + 16'd1;
        end
    end

    assign instr_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: vector table, corner sequences and random stimulus vs a model.
module tb_fetch_unit;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic       start = 0, halt = 0, stall = 0, jump_en = 0, branch_en = 0, branch_cond = 0;
    logic [4:0] jump_idx = 0, br_offset = 0;
    logic [9:0] prog_ctr;
    logic       running, done;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] instr_cnt;
`endif

    fetch_unit dut (
        .Clk(Clk), .Reset_n(Reset_n), .start(start), .halt(halt), .stall(stall),
        .jump_en(jump_en), .jump_idx(jump_idx), .branch_en(branch_en),
        .branch_cond(branch_cond), .br_offset(br_offset),
`ifdef FETCH_PERF_CNT_EN
        .instr_cnt(instr_cnt),
`endif
        .prog_ctr(prog_ctr), .running(running), .done(done)
    );

    always #5 Clk = ~Clk;

    int total = 0;
    int bad   = 0;

    // reference model: 0 idle, 1 run, 2 halted, 3 done
    int m_st = 0, m_pc = 0, m_cnt = 0;
    int jt [32];

    function automatic int wrap(input int v);
        return ((v % 1024) + 1024) % 1024;
    endfunction

    function automatic int sx(input logic [4:0] v);
        return (v >= 16) ? int'(v) - 32 : int'(v);
    endfunction

    task automatic model_update();
        if (start) begin
            m_st = 1; m_pc = 0; m_cnt = 0;
        end else if (m_st == 1) begin
            if (!halt && !stall && m_cnt < 65535) m_cnt++;
            if (halt)                m_st = 2;
            else if (stall)          m_pc = m_pc;
            else if (jump_en)        m_pc = jt[jump_idx];
            else if (branch_en)      m_pc = branch_cond ? wrap(m_pc + sx(br_offset)) : wrap(m_pc + 1);
            else if (m_pc == 1023)   m_st = 3;
            else                     m_pc = wrap(m_pc + 1);
        end
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"}, int'(prog_ctr), m_pc);
        chk({tag, ".running"}, int'(running), int'(m_st == 1));
        chk({tag, ".done"}, int'(done), int'(m_st == 3));
`ifdef FETCH_PERF_CNT_EN
        chk({tag, ".cnt"}, int'(instr_cnt), m_cnt);
`endif
    endtask

    task automatic clr();
        start = 0; halt = 0; stall = 0; jump_en = 0; branch_en = 0; branch_cond = 0;
        jump_idx = 0; br_offset = 0;
    endtask

    task automatic step(input string tag);
        @(posedge Clk);
        model_update();
        #1;
        chk_model(tag);
    endtask

    typedef struct {
        logic st, hl, sl, je;
        logic [4:0] ji;
        logic be, bc;
        logic [4:0] off;
        int   pc;
        logic run, dn;
    } vec_t;

    vec_t vecs [17];

    function automatic vec_t mk(input logic st, hl, sl, je, input logic [4:0] ji,
                                input logic be, bc, input logic [4:0] off,
                                input int pc, input logic run, dn);
        vec_t v;
        v.st = st; v.hl = hl; v.sl = sl; v.je = je; v.ji = ji;
        v.be = be; v.bc = bc; v.off = off; v.pc = pc; v.run = run; v.dn = dn;
        return v;
    endfunction

    initial begin
        foreach (jt[i]) jt[i] = 0;
        jt[1] = 16; jt[2] = 64; jt[3] = 512;

        //              st hl sl je ji    be bc off     pc    run dn
        vecs[0]  = mk(1, 0, 0, 0, 5'd0, 0, 0, 5'd0,  0,    1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0,  1,    1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0,  2,    1, 0);
        vecs[3]  = mk(0, 0, 0, 1, 5'd1, 0, 0, 5'd0,  16,   1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 5'd0, 1, 1, 5'd28, 12,   1, 0);
        vecs[5]  = mk(0, 0, 0, 0, 5'd0, 1, 0, 5'd28, 13,   1, 0);
        vecs[6]  = mk(0, 0, 0, 1, 5'd2, 1, 1, 5'd1,  64,   1, 0);
        vecs[7]  = mk(0, 0, 1, 0, 5'd0, 0, 0, 5'd0,  64,   1, 0);
        vecs[8]  = mk(0, 0, 1, 1, 5'd1, 0, 0, 5'd0,  64,   1, 0);
        vecs[9]  = mk(0, 0, 0, 1, 5'd7, 0, 0, 5'd0,  0,    1, 0);
        vecs[10] = mk(0, 0, 0, 0, 5'd0, 1, 1, 5'd15, 15,   1, 0);
        vecs[11] = mk(0, 1, 0, 0, 5'd0, 0, 0, 5'd0,  15,   0, 0);
        vecs[12] = mk(0, 0, 0, 1, 5'd1, 0, 0, 5'd0,  15,   0, 0);
        vecs[13] = mk(1, 1, 0, 0, 5'd0, 0, 0, 5'd0,  0,    1, 0);
        vecs[14] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0,  1,    1, 0);
        vecs[15] = mk(0, 0, 0, 0, 5'd0, 1, 1, 5'd16, 1009, 1, 0);
        vecs[16] = mk(0, 0, 0, 0, 5'd0, 0, 0, 5'd0,  1010, 1, 0);

        // reset state
        #2;
        chk("rst.pc", int'(prog_ctr), 0);
        chk("rst.running", int'(running), 0);
        chk("rst.done", int'(done), 0);
        @(negedge Clk);
        Reset_n = 1;
        step("idle");

        // table-driven vectors
        for (int i = 0; i < 17; i++) begin
            start = vecs[i].st; halt = vecs[i].hl; stall = vecs[i].sl; jump_en = vecs[i].je;
            jump_idx = vecs[i].ji; branch_en = vecs[i].be; branch_cond = vecs[i].bc;
            br_offset = vecs[i].off;
            step($sformatf("vec%0d", i));
            chk($sformatf("vec%0d.pc_exp", i), int'(prog_ctr), vecs[i].pc);
            chk($sformatf("vec%0d.run_exp", i), int'(running), int'(vecs[i].run));
            chk($sformatf("vec%0d.done_exp", i), int'(done), int'(vecs[i].dn));
        end
        clr();

        // async reset mid-RUN at PC=37
        start = 1; step("s37"); start = 0;
        for (int i = 0; i < 37; i++) step("inc37");
        chk("pc37", int'(prog_ctr), 37);
        #2;
        Reset_n = 0;
        #1;
        chk("async.pc", int'(prog_ctr), 0);
        chk("async.running", int'(running), 0);
        chk("async.done", int'(done), 0);
        m_st = 0; m_pc = 0; m_cnt = 0;
        @(negedge Clk);
        Reset_n = 1;
        step("post_rst");

        // wrap via branch at 1022, jump at END_ADDR, then program completion
        start = 1; step("s_end"); start = 0;
        jump_en = 1; jump_idx = 3; step("j512"); clr();
        for (int i = 0; i < 510; i++) step("to1022");
        chk("pc1022", int'(prog_ctr), 1022);
        branch_en = 1; branch_cond = 1; br_offset = 5'd3; step("wrap"); clr();
        chk("wrap.pc", int'(prog_ctr), 1);
        jump_en = 1; jump_idx = 3; step("j512b"); clr();
        for (int i = 0; i < 511; i++) step("to1023");
        chk("pc1023", int'(prog_ctr), 1023);
        jump_en = 1; jump_idx = 1; step("jend"); clr();
        chk("jend.pc", int'(prog_ctr), 16);
        chk("jend.running", int'(running), 1);
        jump_en = 1; jump_idx = 3; step("j512c"); clr();
        for (int i = 0; i < 511; i++) step("to1023b");
        step("end");
        chk("end.pc", int'(prog_ctr), 1023);
        chk("end.done", int'(done), 1);
        chk("end.running", int'(running), 0);
        jump_en = 1; jump_idx = 2;
        for (int i = 0; i < 3; i++) step("done_hold");
        clr();
        chk("done_hold.pc", int'(prog_ctr), 1023);
        chk("done_hold.done", int'(done), 1);
        start = 1; step("restart"); clr();
        chk("restart.pc", int'(prog_ctr), 0);
        chk("restart.done", int'(done), 0);

        // randomized stimulus against the model
        for (int i = 0; i < 600; i++) begin
            start       = ($urandom_range(0, 40) == 0);
            halt        = ($urandom_range(0, 30) == 0);
            stall       = ($urandom_range(0, 5) == 0);
            jump_en     = ($urandom_range(0, 7) == 0);
            jump_idx    = 5'($urandom_range(0, 31));
            branch_en   = ($urandom_range(0, 3) == 0);
            branch_cond = 1'($urandom_range(0, 1));
            br_offset   = 5'($urandom_range(0, 31));
            step("rand");
        end
        clr();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
